// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared constants, state enum and request helpers for the load/store master
// Contents: address width, funct3 access kinds, data-store mode encodings, FSM state type,
// and helpers that classify a request as illegal or misaligned (split into byte beats).
package lsu_pkg;

    localparam int ADDR_W = 12;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] MODE_WORD = 2'b00;
    localparam logic [1:0] MODE_BYTE = 2'b01;
    localparam logic [1:0] MODE_HALF = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        XFER = 2'b01,
        DONE = 2'b10
    } state_t;

    // Reserved encodings, and unsigned kinds which only make sense for loads.
    function automatic logic is_illegal(input logic we, input logic [2:0] f3);
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (we && f3[2]);
    endfunction

    // A half or word that straddles its natural boundary is issued as byte beats.
    function automatic logic is_split(input logic [2:0] f3, input logic [1:0] a);
        logic s;
        case (f3[1:0])
            2'b01:   s = a[0];
            2'b10:   s = (a != 2'b00);
            default: s = 1'b0;
        endcase
        return s;
    endfunction

    function automatic logic [1:0] native_mode(input logic [2:0] f3);
        logic [1:0] m;
        case (f3[1:0])
            2'b00:   m = MODE_BYTE;
            2'b01:   m = MODE_HALF;
            default: m = MODE_WORD;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lsu_lane_ext.sv
// rtl/lsu_lane_ext.sv - combinational byte-lane assembly and load extension
// Ports: funct3/split/beat select the lane; acc is the partially assembled load word;
// mem_dout is the current read data; wdata is the registered store data.
// acc_next is acc with this beat's data merged, ext_data the extended load result,
// wr_byte the store byte carried by the current split beat.
module lsu_lane_ext
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic        split,
    input  logic [1:0]  beat,
    input  logic [31:0] acc,
    input  logic [31:0] mem_dout,
    input  logic [31:0] wdata,
    output logic [31:0] acc_next,
    output logic [31:0] ext_data,
    output logic [7:0]  wr_byte
);

    always_comb begin
        acc_next = acc;
        if (split) begin
            acc_next[{beat, 3'b000} +: 8] = mem_dout[7:0];
        end else begin
            acc_next = mem_dout;
        end
    end

    always_comb begin
        case (funct3)
            F3_B:    ext_data = {{24{acc[7]}}, acc[7:0]};
            F3_H:    ext_data = {{16{acc[15]}}, acc[15:0]};
            F3_BU:   ext_data = {24'h0, acc[7:0]};
            F3_HU:   ext_data = {16'h0, acc[15:0]};
            default: ext_data = acc;
        endcase
    end

    assign wr_byte = wdata[{beat, 3'b000} +: 8];

endmodule

// File: rtl/lsu_mem_master.sv
// rtl/lsu_mem_master.sv - load/store master issuing aligned or byte-split accesses to a data store
// Ports: clk/clr (sync active-high reset); req_* handshake with op, funct3, address and
// store data; resp_* one-cycle completion with load data and error flag; mem_* drive a
// combinational-read, edge-write data store (mem_dout returns right-aligned read data).
module lsu_mem_master
    import lsu_pkg::*;
(
    input  logic              clk,
    input  logic              clr,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_str,
    output logic [1:0]        mem_mode,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    input  logic [31:0]       mem_dout
);

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic                err_q, err_d;
    logic [2:0]          f3_q, f3_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [1:0]          beat_q, beat_d;
    logic [31:0]         acc_q, acc_d;

    logic                split;
    logic                last_beat;
    logic [31:0]         acc_next;
    logic [31:0]         ext_data;
    logic [7:0]          wr_byte;

    assign split     = is_split(f3_q, addr_q[1:0]);
    assign last_beat = !split || (beat_q == (f3_q[1] ? 2'd3 : 2'd1));

    lsu_lane_ext u_lane (
        .funct3   (f3_q),
        .split    (split),
        .beat     (beat_q),
        .acc      (acc_q),
        .mem_dout (mem_dout),
        .wdata    (wdata_q),
        .acc_next (acc_next),
        .ext_data (ext_data),
        .wr_byte  (wr_byte)
    );

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        err_d      = err_q;
        f3_d       = f3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        beat_d     = beat_q;
        acc_d      = acc_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = 32'h0;
        mem_str    = 1'b0;
        mem_mode   = MODE_WORD;
        mem_addr   = '0;
        mem_din    = 32'h0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    beat_d  = 2'd0;
                    acc_d   = 32'h0;
                    err_d   = is_illegal(req_we, req_funct3);
                    state_d = err_d ? DONE : XFER;
                end
            end
            XFER: begin
                // Gated by clr so an aborted beat never reaches the store.
                mem_str = we_q && !clr;
                if (split) begin
                    mem_mode = MODE_BYTE;
                    mem_addr = addr_q + {{(ADDR_W-2){1'b0}}, beat_q};
                    mem_din  = {24'h0, wr_byte};
                end else begin
                    mem_mode = native_mode(f3_q);
                    mem_addr = addr_q;
                    case (f3_q[1:0])
                        2'b00:   mem_din = {24'h0, wdata_q[7:0]};
                        2'b01:   mem_din = {16'h0, wdata_q[15:0]};
                        default: mem_din = wdata_q;
                    endcase
                end
                acc_d  = acc_next;
                beat_d = beat_q + 2'd1;
                if (last_beat) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                resp_rdata = (!we_q && !err_q) ? ext_data : 32'h0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            beat_q  <= 2'd0;
            acc_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            err_q   <= err_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            beat_q  <= beat_d;
            acc_q   <= acc_d;
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// tb/tb_lsu_mem_master.sv - self-checking bench for lsu_mem_master with a byte-array data store
module tb_lsu_mem_master;

    logic        clk = 1'b0;
    logic        clr;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_str;
    logic [1:0]  mem_mode;
    logic [11:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    logic [7:0]  mem     [0:4095];
    logic [7:0]  ref_mem [0:4095];
    logic        preload;
    int          cyc      = 0;
    int          str_cnt  = 0;
    int          str_last = -10;
    int          str_run  = 0;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    lsu_mem_master dut (
        .clk        (clk),
        .clr        (clr),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_str    (mem_str),
        .mem_mode   (mem_mode),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout)
    );

    // Data store: combinational little-endian read, write on the clock edge.
    always_comb begin
        case (mem_mode)
            2'b01:   mem_dout = {24'h0, mem[mem_addr]};
            2'b10:   mem_dout = {16'h0, mem[mem_addr + 12'd1], mem[mem_addr]};
            default: mem_dout = {mem[mem_addr + 12'd3], mem[mem_addr + 12'd2],
                                 mem[mem_addr + 12'd1], mem[mem_addr]};
        endcase
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (preload) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 8'(i * 7 + 3);
        end else if (mem_str) begin
            str_cnt  <= str_cnt + 1;
            str_last <= cyc;
            str_run  <= (str_last == cyc - 1) ? str_run + 1 : 1;
            mem[mem_addr] <= mem_din[7:0];
            if (mem_mode != 2'b01) mem[mem_addr + 12'd1] <= mem_din[15:8];
            if (mem_mode == 2'b00) begin
                mem[mem_addr + 12'd2] <= mem_din[23:16];
                mem[mem_addr + 12'd3] <= mem_din[31:24];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference behaviour from the access rules: bytes, sizes, alignment and extension.
    task automatic model_op(input logic we, input logic [2:0] f3, input logic [11:0] a,
                            input logic [31:0] wd, output logic e, output logic [31:0] rd,
                            output int lat, output int nwr);
        int size;
        logic [31:0] v;
        size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        e    = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3[2]);
        rd   = 0;
        lat  = 1;
        nwr  = 0;
        if (!e) begin
            lat = ((int'(a) % size) != 0) ? size + 1 : 2;
            if (we) begin
                nwr = ((int'(a) % size) != 0) ? size : 1;
                for (int i = 0; i < size; i++)
                    ref_mem[(int'(a) + i) % 4096] = 8'((wd >> (8 * i)) & 32'hFF);
            end else begin
                v = 0;
                for (int i = 0; i < size; i++)
                    v = v | (32'(ref_mem[(int'(a) + i) % 4096]) << (8 * i));
                if (!f3[2] && size < 4 && v[8 * size - 1])
                    v = v | (32'hFFFF_FFFF << (8 * size));
                rd = v;
            end
        end
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [11:0] a,
                          input logic [31:0] wd, input string tag, output logic [31:0] rd_obs);
        logic        e_exp;
        logic [31:0] rd_exp;
        int          lat_exp, nwr_exp, lat, s0;
        model_op(we, f3, a, wd, e_exp, rd_exp, lat_exp, nwr_exp);
        @(negedge clk);
        check({tag, " ready"}, 32'(req_ready), 32'd1);
        s0 = str_cnt;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        // Garbage on req_* while busy must be ignored.
        req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = 12'($urandom); req_wdata = $urandom;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rd_obs = resp_rdata;
        check({tag, " latency"}, 32'(lat), 32'(lat_exp));
        check({tag, " err"}, 32'(resp_err), 32'(e_exp));
        check({tag, " rdata"}, resp_rdata, rd_exp);
        check({tag, " strobes"}, 32'(str_cnt - s0), 32'(nwr_exp));
        @(negedge clk);
        check({tag, " pulse"}, 32'({resp_valid, req_ready}), 32'b01);
    endtask

    task automatic mem_compare(input string tag);
        int diffs = 0;
        for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) diffs++;
        check(tag, 32'(diffs), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [2:0]  f3;
        logic [11:0] a;
        logic [6:0]  hist;
        int          s0, r, bad;
        logic [5:0]  rdy_v, rsp_v;

        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'(i * 7 + 3);
        clr = 1'b1; preload = 1'b1; req_valid = 1'b0; req_we = 1'b0;
        req_funct3 = 3'b0; req_addr = 12'h0; req_wdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        preload = 1'b0;
        check("reset ready", 32'(req_ready), 32'd1);
        check("reset resp", {29'h0, resp_valid, resp_err, mem_str}, 32'h0);
        check("reset rdata", resp_rdata, 32'h0);
        check("reset mem", {mem_mode, mem_addr, mem_din[17:0]} | {14'h0, mem_din[31:18]}, 32'h0);
        @(negedge clk);
        clr = 1'b0;

        // Aligned word store, then byte loads with sign and zero extension.
        do_req(1'b1, 3'b010, 12'h010, 32'h8000_00F1, "sw aligned", rd);
        do_req(1'b0, 3'b000, 12'h010, 32'h0, "lb", rd);
        check("lb value", rd, 32'hFFFF_FFF1);
        do_req(1'b0, 3'b100, 12'h013, 32'h0, "lbu", rd);
        check("lbu value", rd, 32'h0000_0080);

        // Misaligned word split into four consecutive byte writes.
        do_req(1'b1, 3'b010, 12'h005, 32'hAABB_CCDD, "sw split", rd);
        check("sw split consecutive", 32'(str_run), 32'd4);
        do_req(1'b0, 3'b010, 12'h005, 32'h0, "lw split", rd);
        check("lw split value", rd, 32'hAABB_CCDD);

        // Half store that wraps past the top of the address space.
        do_req(1'b1, 3'b001, 12'hFFF, 32'h0000_1234, "sh wrap", rd);
        check("sh wrap lo", 32'(mem[12'hFFF]), 32'h34);
        check("sh wrap hi", 32'(mem[12'h000]), 32'h12);
        do_req(1'b0, 3'b101, 12'hFFF, 32'h0, "lhu wrap", rd);
        check("lhu wrap value", rd, 32'h0000_1234);

        // Illegal unsigned store.
        do_req(1'b1, 3'b100, 12'h020, 32'hDEAD_BEEF, "illegal store", rd);
        mem_compare("illegal memory");

        // Reset during the second beat of a split store.
        @(negedge clk);
        s0 = str_cnt;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 12'h021; req_wdata = 32'h1122_3344;
        ref_mem[12'h021] = 8'h44;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("abort ready", 32'(req_ready), 32'd1);
        bad = 0;
        repeat (6) begin
            if (resp_valid) bad++;
            @(negedge clk);
        end
        check("abort no resp", 32'(bad), 32'd0);
        check("abort strobes", 32'(str_cnt - s0), 32'd1);
        mem_compare("abort memory");

        // Reset wins over a simultaneous acceptance.
        s0 = str_cnt;
        clr = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 12'h040; req_wdata = 32'h5555_AAAA;
        @(negedge clk);
        clr = 1'b0; req_valid = 1'b0;
        bad = 0;
        repeat (6) begin
            if (resp_valid || !req_ready) bad++;
            @(negedge clk);
        end
        check("clr drop", 32'(bad), 32'd0);
        check("clr drop strobes", 32'(str_cnt - s0), 32'd0);

        // req_valid held high: accept once per IDLE visit, next one right after DONE.
        req_we = 1'b0; req_funct3 = 3'b010; req_addr = 12'h010; req_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rdy_v[i] = req_ready;
            rsp_v[i] = resp_valid;
            @(negedge clk);
        end
        req_valid = 1'b0;
        check("held ready", 32'(rdy_v), 32'b001001);
        check("held resp", 32'(rsp_v), 32'b100100);
        repeat (3) @(negedge clk);

        // Random traffic against the reference model.
        for (int n = 0; n < 60; n++) begin
            r = int'($urandom_range(0, 9));
            case (r)
                0, 1: f3 = 3'b000;
                2, 3: f3 = 3'b001;
                4, 5: f3 = 3'b010;
                6:    f3 = 3'b100;
                7:    f3 = 3'b101;
                default: begin
                    hist = 7'($urandom_range(0, 2));
                    f3 = (hist == 0) ? 3'b011 : (hist == 1) ? 3'b110 : 3'b111;
                end
            endcase
            a = ($urandom_range(0, 3) == 0) ? 12'(12'hFFC + $urandom_range(0, 3)) : 12'($urandom);
            do_req(1'($urandom), f3, a, $urandom, "random", rd);
        end
        mem_compare("final memory");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/lsu_mem_master.md
LSU_MEM_MASTER -- requirements
Module: lsu_mem_master

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port clr, input, 1, reset; synchronous and active-high.
REQ-003 SHALL have port req_valid, input, 1, a load/store request is presented.
REQ-004 SHALL have port req_ready, output, 1, the request is accepted when req_valid and req_ready are both high at a rising edge.
REQ-005 SHALL have port req_we, input, 1, 1 = store, 0 = load.
REQ-006 SHALL have port req_funct3, input, 3, access kind: 000 byte, 001 half, 010 word, 100 byte-unsigned, 101 half-unsigned.
REQ-007 SHALL have port req_addr, input, 12, byte address.
REQ-008 SHALL have port req_wdata, input, 32, store data, right-aligned.
REQ-009 SHALL have port resp_valid, output, 1, a one-cycle completion pulse.
REQ-010 SHALL have port resp_rdata, output, 32, load result, extended to 32 bits.
REQ-011 SHALL have port resp_err, output, 1, the request was illegal and no memory access occurred.
REQ-012 SHALL have port mem_str, output, 1, store strobe to the data store; the store writes on the clk edge.
REQ-013 SHALL have port mem_mode, output, 2, access mode: 00 word, 01 byte, 10 half.
REQ-014 SHALL have port mem_addr, output, 12, byte address to the data store.
REQ-015 SHALL have port mem_din, output, 32, right-aligned write data.
REQ-016 SHALL have port mem_dout, input, 32, combinational, right-aligned read data from the data store.

Function
REQ-017 SHALL use the FSM states IDLE, XFER and DONE; req_ready SHALL be 1 only in IDLE.
REQ-018 SHALL register op, address and wdata on acceptance and move IDLE->XFER, or IDLE->DONE when the request is illegal.
REQ-019 SHALL treat as illegal: funct3 in {011, 110, 111}, and stores with funct3[2]=1.
REQ-020 SHALL perform an aligned access (word with addr[1:0]=00, half with addr[0]=0, any byte) as one XFER beat with native mem_mode.
REQ-021 SHALL split a misaligned access into byte beats: a word becomes 4 beats, a half becomes 2 beats.
REQ-022 SHALL order split beats little-endian at addresses A, A+1, ...; beat k carries data bits [8k+7:8k].
REQ-023 SHALL wrap beat addresses modulo 4096 (0xFFF+1 = 0x000).
REQ-024 SHALL drive exactly one memory access per XFER cycle, and SHALL assert mem_str only in XFER and only for stores.
REQ-025 SHALL capture read data from mem_dout at the end of each XFER cycle into the assembled result.
REQ-026 SHALL move from the last XFER beat to DONE; DONE SHALL last one cycle with resp_valid=1 and then return to IDLE.
REQ-027 SHALL have these latencies from the accept edge to resp_valid high: 2 cycles aligned, 3 for a split half, 5 for a split word, 1 for an illegal request.
REQ-028 SHALL sign-extend loads with funct3 000/001 and zero-extend loads with funct3 100/101.
REQ-029 SHALL drive resp_rdata as the result for loads and 0 for stores and errors, valid only while resp_valid is high.
REQ-030 SHALL drive these outputs in IDLE and DONE: mem_str=0, mem_mode=00, mem_addr=0, mem_din=0.
REQ-031 SHALL ignore req_* outside IDLE; there is no queueing.

Reset
REQ-032 SHALL, on clr=1 at a rising edge, enter IDLE with req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0 and all mem_* outputs 0.
REQ-033 SHALL, on clr mid-XFER, abort the operation: remaining beats are not issued and no response follows.
REQ-034 SHALL let clr take priority over a simultaneous acceptance, so the request is dropped.

Structure
REQ-035 SHALL define in shared package lsu_pkg: the funct3 constants, the mem_mode encodings, the state enum and the 12-bit address width.
REQ-036 SHALL place sign/zero extension and byte-beat data assembly in sub-module lsu_lane_ext, which is purely combinational.

Verification
REQ-037 SHALL be verified against a behavioural model of the 4 KB byte-addressable data store, with these directed scenarios:
REQ-038 SHALL pass: sw 0x8000_00F1 @0x010, then lb @0x010 -> rdata 0xFFFF_FFF1; lbu @0x013 -> 0x0000_0080; first resp_valid 2 cycles after accept.
REQ-039 SHALL pass: sw 0xAABB_CCDD @0x005 (misaligned) -> 4 byte writes to 0x005..0x008 in 4 consecutive cycles; lw @0x005 -> 0xAABB_CCDD with resp 5 cycles after accept.
REQ-040 SHALL pass: sh 0x1234 @0xFFF -> bytes 0x34 @0xFFF and 0x12 @0x000 (wrap); lhu @0xFFF -> 0x0000_1234.
REQ-041 SHALL pass: request with req_we=1, funct3=100 -> resp_err=1 one cycle after accept, no mem_str pulse, memory unchanged.
REQ-042 SHALL pass: clr asserted in the 2nd beat of a misaligned sw -> only the first byte is written, no resp_valid, req_ready=1 on the next cycle.
REQ-043 SHALL pass: req_valid held high throughout a transfer -> exactly one acceptance per IDLE visit, with the back-to-back accept on the cycle after DONE.
